imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 128, number of 32-bit words loaded per session (1..1024).
REQ-002 SHALL have parameter ADDR_W, default 32, width of the byte address presented to instruction memory.
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load session.
REQ-006 SHALL have port in_data  input  8  incoming instruction byte.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 SHALL have port mem_addr  output  ADDR_W  byte address of the word written.
REQ-011 SHALL have port mem_wdata  output  32  word written.
REQ-012 SHALL have port cpu_hold  output  1  holds the fetch unit/PC in reset while loading.
REQ-013 SHALL have port busy  output  1  session in progress.
REQ-014 SHALL have port done  output  1  sticky; last session completed.
REQ-015 SHALL have port checksum_err  output  1  sticky; checksum mismatch on last session.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, WRITE, CHECK, DONE.
REQ-017 IDLE -> COLLECT on start; clears done, checksum_err, byte counter, word counter, address (0).
REQ-018 A byte SHALL transfer only on a cycle with in_valid=1 and in_ready=1; in_ready=1 only in COLLECT and CHECK.
REQ-019 Bytes SHALL assemble big-endian: first byte to [31:24], fourth to [7:0].
REQ-020 On the fourth accepted byte, COLLECT -> WRITE; in the next cycle mem_we=1 with assembled word and current address (latency one cycle).
REQ-021 WRITE lasts exactly one cycle; mem_addr SHALL then advance by 4; word counter +1.
REQ-022 WRITE -> COLLECT if words written < NUM_WORDS, else -> CHECK (macro defined) or DONE (macro undefined).
REQ-023 mem_we, mem_addr, mem_wdata SHALL be driven only from registers; mem_we=0 outside WRITE.
REQ-024 cpu_hold and busy SHALL be 1 in COLLECT, WRITE, CHECK; 0 in IDLE and DONE.
REQ-025 DONE SHALL assert done and return to IDLE next cycle; done stays 1 until next start or Reset.
REQ-026 start while busy SHALL be ignored.
REQ-027 in_valid deasserting mid-word SHALL stall assembly without losing accepted bytes.
REQ-028 Address SHALL never wrap within a session; NUM_WORDS*4 must fit ADDR_W.

Reset
REQ-029 Reset SHALL force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, checksum_err=0, counters=0.
REQ-030 Reset mid-session SHALL abandon the session; no further mem_we until a new start.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN defined: loader SHALL XOR-accumulate all data bytes, accept one trailing byte in CHECK, set checksum_err if it differs from the accumulator, then go to DONE (done asserted regardless).
REQ-032 Macro undefined: no CHECK state, no trailing byte, checksum_err tied 0.

Structure
REQ-033 State encoding and the default NUM_WORDS constant SHALL live in a shared package imem_loader_pkg.
REQ-034 A sub-module byte_assembler (4-byte shift register + count, emits word_valid) SHALL be used.

Verification
REQ-035 NUM_WORDS=2, bytes 20 08 00 05 8C 09 00 00 continuous -> mem_we at addr 0 data 0x20080005, addr 4 data 0x8C090000; done=1, cpu_hold=0 after.
REQ-036 Same stream with in_valid low 3 cycles after 2nd byte -> identical writes, later by 3 cycles.
REQ-037 Reset asserted after 5th byte -> outputs at reset values immediately; new start reloads from addr 0.
REQ-038 Macro defined, bytes 01 02 03 04 then 04 -> checksum_err=0; trailing 05 -> checksum_err=1, done=1.
REQ-039 start pulsed during COLLECT -> counters and address unchanged.
REQ-040 NUM_WORDS=128 random stream -> 128 mem_we pulses, last addr 0x1FC, in_ready=0 during every WRITE cycle.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the FSM state encoding and the default session length.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DEFAULT_NUM_WORDS = 128;

endpackage

// File: rtl/byte_assembler.sv
// Packs four bytes big-endian into one word.
// word_valid flags the cycle the fourth byte is accepted.
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] sr;
    logic [1:0]  cnt;

    assign word       = {sr, byte_in};
    assign word_valid = byte_valid && (cnt == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (byte_valid) begin
            sr  <= {sr[15:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory while holding the CPU.
// IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter int ADDR_W    = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              checksum_err
);

    localparam int CW = $clog2(NUM_WORDS + 1);

    state_t        state, state_nx;
    logic [CW-1:0] wcnt;
    logic [31:0]   word;
    logic          wvalid;
    logic          xfer;
    logic          last_word;
    logic          sess_go;

    assign in_ready  = (state == COLLECT) || (state == CHECK);
    assign xfer      = in_valid && in_ready;
    assign busy      = (state == COLLECT) || (state == WRITE)
                    || (state == CHECK);
    assign cpu_hold  = busy;
    assign last_word = (wcnt == CW'(NUM_WORDS - 1));
    assign sess_go   = (state == IDLE) && start;

    byte_assembler u_asm (
        .clk        (Clk),
        .rst        (Reset),
        .clr        (sess_go),
        .byte_valid (xfer && (state == COLLECT)),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (wvalid)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = COLLECT;
            COLLECT: if (wvalid) state_nx = WRITE;
            WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nx = CHECK;
`else
                    state_nx = DONE;
`endif
                end else begin
                    state_nx = COLLECT;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:   if (xfer) state_nx = DONE;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Memory port is fully registered; address advances after each write
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wcnt      <= '0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (sess_go) begin
                mem_addr <= '0;
                wcnt     <= '0;
                done     <= 1'b0;
            end
            if (wvalid) begin
                mem_we    <= 1'b1;
                mem_wdata <= word;
            end
            if (state == WRITE) begin
                mem_addr <= mem_addr + ADDR_W'(4);
                wcnt     <= wcnt + CW'(1);
            end
            if ((state_nx == DONE) && (state != DONE))
                done <= 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] acc;
    logic       cerr;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc  <= '0;
            cerr <= 1'b0;
        end else if (sess_go) begin
            acc  <= '0;
            cerr <= 1'b0;
        end else if (xfer && (state == COLLECT)) begin
            acc <= acc ^ in_data;
        end else if (xfer && (state == CHECK)) begin
            cerr <= (in_data != acc);
        end
    end

    assign checksum_err = cerr;
`else
    assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed + random bench for imem_loader (2-word and 128-word builds).
module tb_imem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset, start_b, valid_b, sel;
    logic [7:0] data_b;

    logic        rdy2, we2, hold2, busy2, done2, cerr2;
    logic [31:0] addr2, wd2;
    logic        rdy128, we128, hold128, busy128, done128, cerr128;
    logic [31:0] addr128, wd128;

    logic rdy_s, done_s;
    assign rdy_s  = sel ? rdy128 : rdy2;
    assign done_s = sel ? done128 : done2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;
    int start_cyc;
    wr_t q2[$];
    wr_t q128[$];
    int  xcyc[$];

    imem_loader #(.NUM_WORDS(2), .ADDR_W(32)) dut2 (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start_b & ~sel),
        .in_data      (data_b),
        .in_valid     (valid_b & ~sel),
        .in_ready     (rdy2),
        .mem_we       (we2),
        .mem_addr     (addr2),
        .mem_wdata    (wd2),
        .cpu_hold     (hold2),
        .busy         (busy2),
        .done         (done2),
        .checksum_err (cerr2)
    );

    imem_loader #(.NUM_WORDS(128), .ADDR_W(32)) dut128 (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start_b & sel),
        .in_data      (data_b),
        .in_valid     (valid_b & sel),
        .in_ready     (rdy128),
        .mem_we       (we128),
        .mem_addr     (addr128),
        .mem_wdata    (wd128),
        .cpu_hold     (hold128),
        .busy         (busy128),
        .done         (done128),
        .checksum_err (cerr128)
    );

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (we2)
            q2.push_back('{addr: addr2, data: wd2, cyc: cyc});
        if (we128)
            q128.push_back('{addr: addr128, data: wd128, cyc: cyc});
        if ((we2 && rdy2) || (we128 && rdy128))
            viol = viol + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] b[$]);
        logic [7:0] r = 8'h00;
        foreach (b[i]) r = r ^ b[i];
        return r;
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        if (gap > 0) begin
            valid_b = 1'b0;
            repeat (gap) @(posedge Clk);
            #1;
        end
        data_b  = b;
        valid_b = 1'b1;
        @(negedge Clk);
        while (rdy_s !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(n), 64'(0));
        @(posedge Clk);
        #1;
        valid_b = 1'b0;
        xcyc.push_back(cyc);
    endtask

    task automatic begin_session();
        start_b = 1'b1;
        @(posedge Clk);
        #1;
        start_b   = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic load(input logic [7:0] b[$], input int stall_at,
                        input int stall_n, input int restart_at,
                        input bit rgap);
        for (int i = 0; i < b.size(); i++) begin
            int g = 0;
            if (i == restart_at) begin
                valid_b = 1'b0;
                start_b = 1'b1;
                @(posedge Clk);
                #1;
                start_b = 1'b0;
            end
            if (i == stall_at)
                g = stall_n;
            else if (rgap && $urandom_range(0, 3) == 0)
                g = $urandom_range(1, 2);
            send(b[i], g);
        end
    endtask

    task automatic finish_session(input logic [7:0] b[$], input bit badck);
        int n = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(xsum(b) ^ (badck ? 8'h5A : 8'h00), 0);
`else
        if (badck) n = 0;
`endif
        while (done_s !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk("done_wait", 64'(done_s), 64'(1));
        @(posedge Clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input bit big,
                                input int base, input logic [7:0] b[$],
                                input int nw);
        wr_t w;
        int  n;
        n = big ? q128.size() : q2.size();
        chk({tag, ".count"}, 64'(n - base), 64'(nw));
        for (int i = 0; i < nw; i++) begin
            if (base + i < n) begin
                if (big) w = q128[base + i];
                else     w = q2[base + i];
                chk({tag, ".addr"}, 64'(w.addr), 64'(4 * i));
                chk({tag, ".data"}, 64'(w.data),
                    64'({b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]}));
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".in_ready"}, 64'(rdy2), 64'(0));
        chk({tag, ".mem_we"},   64'(we2), 64'(0));
        chk({tag, ".mem_addr"}, 64'(addr2), 64'(0));
        chk({tag, ".wdata"},    64'(wd2), 64'(0));
        chk({tag, ".cpu_hold"}, 64'(hold2), 64'(0));
        chk({tag, ".busy"},     64'(busy2), 64'(0));
        chk({tag, ".done"},     64'(done2), 64'(0));
        chk({tag, ".cksum"},    64'(cerr2), 64'(0));
    endtask

    initial begin
        logic [7:0] fixed[$];
        logic [7:0] bs[$];
        logic [7:0] big[$];
        int b0, xb, r0, r1;

        Reset   = 1'b1;
        start_b = 1'b0;
        valid_b = 1'b0;
        data_b  = 8'h00;
        sel     = 1'b0;
        @(negedge Clk);
        check_reset_vals("rst");
        chk("rst.busy128", 64'(busy128), 64'(0));
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Continuous two-word stream
        fixed = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
        b0 = q2.size();
        xb = xcyc.size();
        begin_session();
        load(fixed, -1, 0, -1, 1'b0);
        chk("t1.busy_mid", 64'(busy2), 64'(1));
        chk("t1.hold_mid", 64'(hold2), 64'(1));
        finish_session(fixed, 1'b0);
        check_writes("t1", 1'b0, b0, fixed, 2);
        chk("t1.lat0", 64'(q2[b0].cyc), 64'(xcyc[xb+3]));
        chk("t1.lat1", 64'(q2[b0+1].cyc), 64'(xcyc[xb+7]));
        r0 = q2[b0].cyc - start_cyc;
        r1 = q2[b0+1].cyc - start_cyc;
        chk("t1.done", 64'(done2), 64'(1));
        chk("t1.hold", 64'(hold2), 64'(0));
        chk("t1.busy", 64'(busy2), 64'(0));
        chk("t1.cksum", 64'(cerr2), 64'(0));

        // Same stream, three idle cycles after the second byte
        b0 = q2.size();
        begin_session();
        chk("t2.done_clr", 64'(done2), 64'(0));
        load(fixed, 2, 3, -1, 1'b0);
        finish_session(fixed, 1'b0);
        check_writes("t2", 1'b0, b0, fixed, 2);
        chk("t2.delay0", 64'(q2[b0].cyc - start_cyc), 64'(r0 + 3));
        chk("t2.delay1", 64'(q2[b0+1].cyc - start_cyc), 64'(r1 + 3));

        // start pulsed mid-session is ignored
        bs = {};
        repeat (8) bs.push_back(8'($urandom));
        b0 = q2.size();
        begin_session();
        load(bs, -1, 0, 2, 1'b0);
        finish_session(bs, 1'b0);
        check_writes("t3", 1'b0, b0, bs, 2);

        // Checksum mismatch (feature build) or tied-off flag
        bs = {};
        repeat (8) bs.push_back(8'($urandom));
        begin_session();
        load(bs, -1, 0, -1, 1'b1);
        finish_session(bs, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t4.cksum_err", 64'(cerr2), 64'(1));
`else
        chk("t4.cksum_off", 64'(cerr2), 64'(0));
`endif
        chk("t4.done", 64'(done2), 64'(1));
        chk("t4.ready_idle", 64'(rdy2), 64'(0));

        // Reset after the fifth byte abandons the session
        bs = {};
        repeat (5) bs.push_back(8'($urandom));
        begin_session();
        load(bs, -1, 0, -1, 1'b0);
        Reset = 1'b1;
        #1;
        check_reset_vals("t5.rst");
        b0 = q2.size();
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        chk("t5.no_write", 64'(q2.size()), 64'(b0));
        bs = {};
        repeat (8) bs.push_back(8'($urandom));
        begin_session();
        load(bs, -1, 0, -1, 1'b0);
        finish_session(bs, 1'b0);
        check_writes("t5", 1'b0, b0, bs, 2);

        // Full 128-word random session with random gaps
        sel = 1'b1;
        repeat (512) big.push_back(8'($urandom));
        b0 = q128.size();
        begin_session();
        load(big, -1, 0, -1, 1'b1);
        finish_session(big, 1'b0);
        check_writes("t6", 1'b1, b0, big, 128);
        if (q128.size() > 0)
            chk("t6.last_addr", 64'(q128[q128.size()-1].addr), 64'h1FC);
        chk("t6.ready_in_write", 64'(viol), 64'(0));
        chk("t6.done", 64'(done128), 64'(1));
        chk("t6.cksum", 64'(cerr128), 64'(0));
        chk("t6.hold", 64'(hold128), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
